irq_controller: RTL and testbench
=================================

Name: irq_controller

Overview:
- Memory-mapped interrupt controller directly downstream of the GPIO/counter-timer io block.
- Consumes the io block's single-cycle interrupt pulses (top, cmpr0, cmpr1), latches them as pending, masks them and selects one by fixed priority.
- Presents one request plus a vector to the CPU core; the core acknowledges on entry and signals return on exit (no nesting).
- Shares the io block's 8-bit din/address/w_en/r_en data bus.

Parameters:
N_IRQ, 3, number of interrupt inputs (1..8); index 0 has the highest priority.
BASE_ADDR, 8'h10, address of the first register; the block decodes BASE_ADDR..BASE_ADDR+3.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
irq_in  input  N_IRQ  interrupt pulses; bit 0 = top_interrupt, bit 1 = cmpr0_interrupt, bit 2 = cmpr1_interrupt
din  input  8  write data
address  input  8  register address
w_en  input  1  write strobe
r_en  input  1  read strobe
dout  output  8  read data, registered
irq  output  1  interrupt request to CPU, registered
irq_vector  output  3  index of the requested source, registered
irq_ack  input  1  CPU accepted the request (1-cycle pulse)
irq_ret  input  1  CPU executed return-from-interrupt (1-cycle pulse)

Behaviour:
- Reset (rst_n low, asynchronous): ENABLE=0, PENDING=0, GIE=0, state=IDLE, irq=0, irq_vector=0, dout=0.
- Register map (offset from BASE_ADDR); other addresses: no write effect, dout holds.
  - +0 ENABLE[N_IRQ-1:0]: read/write; unused bits read 0.
  - +1 PENDING: read; a write of 1 clears the bit, a write of 0 has no effect.
  - +2 CTRL: bit0 = GIE (global enable), read/write.
  - +3 STATUS: read only; bit7 = in_service, bit6 = irq, bits2:0 = irq_vector.
- Reads:
  - dout updates on the edge where r_en is high and the address matches; data is valid the next cycle.
  - dout holds its value otherwise.
- Pending bits:
  - A high sample of irq_in[i] sets PENDING[i], regardless of ENABLE.
  - A set and a W1C clear of the same bit in the same cycle: the set wins.
- eligible = PENDING & ENABLE. sel = lowest index set in eligible.
- FSM (three states):
  - IDLE: if GIE and eligible≠0, go to REQ; irq_vector <= sel.
  - REQ: irq=1.
    - Each cycle irq_vector <= sel, so a higher-priority arrival overrides.
    - If eligible becomes 0 (W1C, mask, or GIE cleared), return to IDLE and drop irq the next cycle.
    - On irq_ack: clear PENDING[irq_vector], go to SERVICE, irq=0.
    - If an ack coincides with a new irq_in on the same bit, the bit stays set.
  - SERVICE: in_service=1; irq=0. On irq_ret, go to IDLE. Pending bits keep accumulating.
- Stray strobes: irq_ack outside REQ and irq_ret outside SERVICE are ignored.
- Latency:
  - irq_in sampled at edge k gives PENDING visible after edge k.
  - irq high after edge k+1 (GIE=1, enabled, state IDLE).
  - From SERVICE, irq_ret at edge r re-raises irq after edge r+1 if eligible≠0.
- Width rule: irq_vector is zero-extended from the sel index; N_IRQ<8 leaves the upper ENABLE/PENDING bits tied to 0.
- Reset mid-operation: return to IDLE immediately; all pending bits are lost.

Test Plan:
- Reset, write ENABLE=3'b111, CTRL=1, pulse irq_in=3'b010 for 1 cycle -> PENDING=0x02 next cycle; irq=1, irq_vector=1 two cycles after the pulse; STATUS reads 0x41.
- In REQ with vector 1, pulse irq_in[0] -> irq_vector becomes 0 while irq stays high; irq_ack -> PENDING=0x02, state SERVICE, STATUS=0x80; irq_ret -> irq re-asserts with vector 1.
- ENABLE=3'b001, pulse irq_in[2] -> PENDING=0x04, irq stays 0; write ENABLE=0x04 -> irq=1, vector 2.
- In REQ on source 1, write 0x02 to PENDING (W1C) -> irq drops the following cycle, state IDLE; simultaneous W1C and irq_in[1] pulse -> PENDING[1] stays 1.
- GIE=0 with pending 0x07 -> irq never asserts; irq_ack/irq_ret pulses change nothing; set GIE=1 -> vector 0.
- Assert rst_n low asynchronously mid-SERVICE -> irq=0, PENDING=0, ENABLE=0, STATUS=0x00 without waiting for a clock edge.

Source files
------------

// File: rtl/irq_controller_if.sv
// irq_controller_if: 8-bit register bus shared with the GPIO/counter-timer io block.
//   din/address/w_en/r_en : driven by the bus master (CPU side)
//   dout                  : registered read data from the slave
interface irq_controller_if;
    logic [7:0] din;
    logic [7:0] address;
    logic       w_en;
    logic       r_en;
    logic [7:0] dout;

    modport master (output din, address, w_en, r_en, input dout);
    modport slave  (input din, address, w_en, r_en, output dout);
endinterface

// File: rtl/irq_controller.sv
// irq_controller: latches interrupt pulses as pending, masks them, picks the
// lowest-index eligible source and presents one request + vector to the core.
// The core acknowledges on entry and signals return on exit (no nesting).
//   clk, rst_n        : clock, asynchronous active-low reset
//   bus (slave)       : din/address/w_en/r_en in, dout out (registered)
//   irq_in[N_IRQ]     : interrupt pulses from the io block
//   irq, irq_vector   : registered request and source index to the core
//   irq_ack, irq_ret  : 1-cycle pulses from the core (entry / return)
// Registers at BASE_ADDR+0..3: ENABLE, PENDING (W1C), CTRL (bit0 GIE), STATUS.
module irq_controller #(
    parameter int         N_IRQ     = 3,
    parameter logic [7:0] BASE_ADDR = 8'h10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    irq_controller_if.slave      bus,
    input  logic [N_IRQ-1:0]     irq_in,
    output logic                 irq,
    output logic [2:0]           irq_vector,
    input  logic                 irq_ack,
    input  logic                 irq_ret
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERVICE} state_t;

    state_t           r_state, w_state_nxt;
    logic [N_IRQ-1:0] r_enable, r_pending;
    logic [N_IRQ-1:0] w_eligible, w_w1c, w_ack_clr, w_pending_nxt;
    logic             r_gie, r_irq;
    logic [2:0]       r_vec, w_vec_nxt, w_sel;
    logic             w_irq_nxt, w_ack_take, w_req;
    logic [7:0]       r_dout, w_rdata, w_off;
    logic             w_hit, w_wr, w_rd;
    logic             w_unused_din;

    // Modular subtraction: offset < 4 exactly when address is in BASE..BASE+3.
    assign w_off = bus.address - BASE_ADDR;
    assign w_hit = (w_off[7:2] == 6'd0);
    assign w_wr  = bus.w_en & w_hit;
    assign w_rd  = bus.r_en & w_hit;

    assign w_unused_din = ^bus.din;

    assign w_eligible = r_pending & r_enable;
    assign w_req      = r_gie & (|w_eligible);

    // Fixed priority: lowest index wins.
    always_comb begin
        w_sel = 3'd0;
        for (int i = N_IRQ - 1; i >= 0; i--)
            if (w_eligible[i]) w_sel = 3'(i);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_vec_nxt   = r_vec;
        w_ack_take  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_state_nxt = S_REQ;
                    w_vec_nxt   = w_sel;
                end
            end
            S_REQ: begin
                // Ack takes precedence; the acked vector is the one on irq_vector.
                if (irq_ack) begin
                    w_ack_take  = 1'b1;
                    w_state_nxt = S_SERVICE;
                end else if (!w_req) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_vec_nxt   = w_sel;
                end
            end
            S_SERVICE: begin
                if (irq_ret) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_irq_nxt = (w_state_nxt == S_REQ);

    always_comb begin
        for (int i = 0; i < N_IRQ; i++)
            w_ack_clr[i] = w_ack_take && (r_vec == 3'(i));
    end

    assign w_w1c = (w_wr && w_off[1:0] == 2'd1) ? bus.din[N_IRQ-1:0] : '0;

    // New pulses are OR-ed in after clears so a coincident set always wins.
    assign w_pending_nxt = (r_pending & ~(w_w1c | w_ack_clr)) | irq_in;

    always_comb begin
        w_rdata = 8'd0;
        case (w_off[1:0])
            2'd0: w_rdata = 8'(r_enable);
            2'd1: w_rdata = 8'(r_pending);
            2'd2: w_rdata = {7'd0, r_gie};
            2'd3: w_rdata = {(r_state == S_SERVICE), r_irq, 3'd0, r_vec};
            default: w_rdata = 8'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_irq   <= 1'b0;
            r_vec   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_irq   <= w_irq_nxt;
            r_vec   <= w_vec_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_enable  <= '0;
            r_pending <= '0;
            r_gie     <= 1'b0;
            r_dout    <= 8'd0;
        end else begin
            r_pending <= w_pending_nxt;
            if (w_wr && w_off[1:0] == 2'd0) r_enable <= bus.din[N_IRQ-1:0];
            if (w_wr && w_off[1:0] == 2'd2) r_gie    <= bus.din[0];
            if (w_rd)                       r_dout   <= w_rdata;
        end
    end

    assign irq        = r_irq;
    assign irq_vector = r_vec;
    assign bus.dout   = r_dout;

endmodule

// File: tb/tb_irq_controller.sv
module tb_irq_controller;

    localparam logic [7:0] A_EN   = 8'h10;
    localparam logic [7:0] A_PEND = 8'h11;
    localparam logic [7:0] A_CTRL = 8'h12;
    localparam logic [7:0] A_STAT = 8'h13;

    logic       clk, rst_n;
    logic [2:0] irq_in;
    logic       irq;
    logic [2:0] irq_vector;
    logic       irq_ack, irq_ret;
    logic [7:0] rdv;
    int         total, bad;

    irq_controller_if bus();

    irq_controller #(.N_IRQ(3), .BASE_ADDR(8'h10)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .irq_in(irq_in), .irq(irq),
        .irq_vector(irq_vector), .irq_ack(irq_ack), .irq_ret(irq_ret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled on the falling edge.
    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.address = a; bus.din = d; bus.w_en = 1'b1;
        @(negedge clk);
        bus.w_en = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        bus.address = a; bus.r_en = 1'b1;
        @(negedge clk);
        bus.r_en = 1'b0;
        d = bus.dout;
    endtask

    task automatic pulse_in(input logic [2:0] v);
        @(negedge clk); irq_in = v;
        @(negedge clk); irq_in = 3'd0;
    endtask

    task automatic test_reset();
        #12;
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
        total++; if (irq_vector !== 3'd0) begin bad++; $display("FAIL reset_vec got=%0d exp=0", irq_vector); end
        total++; if (bus.dout !== 8'h00) begin bad++; $display("FAIL reset_dout got=%h exp=00", bus.dout); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_basic();
        wr(A_EN, 8'h07);
        wr(A_CTRL, 8'h01);
        @(negedge clk); irq_in = 3'b010;
        @(negedge clk); irq_in = 3'b000;      // pulse sampled at edge k
        rd(A_PEND, rdv);                      // dout captured at edge k+1
        total++; if (rdv !== 8'h02) begin bad++; $display("FAIL basic_pend got=%h exp=02", rdv); end
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL basic_irq got=%b exp=1", irq); end
        total++; if (irq_vector !== 3'd1) begin bad++; $display("FAIL basic_vec got=%0d exp=1", irq_vector); end
        rd(A_STAT, rdv);
        total++; if (rdv !== 8'h41) begin bad++; $display("FAIL basic_status got=%h exp=41", rdv); end
        rd(8'h14, rdv);                       // unmapped: dout holds
        total++; if (rdv !== 8'h41) begin bad++; $display("FAIL unmapped_hold got=%h exp=41", rdv); end
    endtask

    task automatic test_priority();
        pulse_in(3'b001);
        @(negedge clk);
        total++; if (irq_vector !== 3'd0) begin bad++; $display("FAIL prio_vec got=%0d exp=0", irq_vector); end
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL prio_irq got=%b exp=1", irq); end
        @(negedge clk); irq_ack = 1'b1;
        @(negedge clk); irq_ack = 1'b0;
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL ack_irq got=%b exp=0", irq); end
        rd(A_PEND, rdv);
        total++; if (rdv !== 8'h02) begin bad++; $display("FAIL ack_pend got=%h exp=02", rdv); end
        rd(A_STAT, rdv);
        total++; if (rdv !== 8'h80) begin bad++; $display("FAIL svc_status got=%h exp=80", rdv); end
        @(negedge clk); irq_ret = 1'b1;
        @(negedge clk); irq_ret = 1'b0;
        @(negedge clk);
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL ret_irq got=%b exp=1", irq); end
        total++; if (irq_vector !== 3'd1) begin bad++; $display("FAIL ret_vec got=%0d exp=1", irq_vector); end
    endtask

    task automatic test_mask();
        wr(A_CTRL, 8'h00);
        wr(A_PEND, 8'h07);
        wr(A_EN, 8'h01);
        wr(A_CTRL, 8'h01);
        pulse_in(3'b100);
        @(negedge clk); @(negedge clk);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL mask_irq got=%b exp=0", irq); end
        rd(A_PEND, rdv);
        total++; if (rdv !== 8'h04) begin bad++; $display("FAIL mask_pend got=%h exp=04", rdv); end
        wr(A_EN, 8'h04);
        @(negedge clk);
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL unmask_irq got=%b exp=1", irq); end
        total++; if (irq_vector !== 3'd2) begin bad++; $display("FAIL unmask_vec got=%0d exp=2", irq_vector); end
    endtask

    task automatic test_w1c();
        wr(A_EN, 8'h06);
        pulse_in(3'b010);
        @(negedge clk);
        total++; if (irq_vector !== 3'd1) begin bad++; $display("FAIL w1c_vec got=%0d exp=1", irq_vector); end
        wr(A_PEND, 8'h06);
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL w1c_irq_hold got=%b exp=1", irq); end
        @(negedge clk);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL w1c_irq_drop got=%b exp=0", irq); end
        rd(A_STAT, rdv);
        total++; if (rdv !== 8'h01) begin bad++; $display("FAIL w1c_status got=%h exp=01", rdv); end
        @(negedge clk);
        bus.address = A_PEND; bus.din = 8'h02; bus.w_en = 1'b1; irq_in = 3'b010;
        @(negedge clk);
        bus.w_en = 1'b0; irq_in = 3'b000;
        rd(A_PEND, rdv);
        total++; if (rdv !== 8'h02) begin bad++; $display("FAIL set_wins got=%h exp=02", rdv); end
    endtask

    task automatic test_gie();
        wr(A_CTRL, 8'h00);
        wr(A_EN, 8'h07);
        pulse_in(3'b111);
        @(negedge clk); irq_ack = 1'b1;
        @(negedge clk); irq_ack = 1'b0; irq_ret = 1'b1;
        @(negedge clk); irq_ret = 1'b0;
        @(negedge clk);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL gie_irq got=%b exp=0", irq); end
        rd(A_PEND, rdv);
        total++; if (rdv !== 8'h07) begin bad++; $display("FAIL gie_pend got=%h exp=07", rdv); end
        rd(A_STAT, rdv);
        total++; if (rdv !== 8'h01) begin bad++; $display("FAIL gie_status got=%h exp=01", rdv); end
        wr(A_CTRL, 8'h01);
        @(negedge clk);
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL gie_on_irq got=%b exp=1", irq); end
        total++; if (irq_vector !== 3'd0) begin bad++; $display("FAIL gie_on_vec got=%0d exp=0", irq_vector); end
    endtask

    task automatic test_async_reset();
        @(negedge clk); irq_ack = 1'b1;
        @(negedge clk); irq_ack = 1'b0;
        rd(A_STAT, rdv);
        total++; if (rdv !== 8'h80) begin bad++; $display("FAIL pre_rst_status got=%h exp=80", rdv); end
        #2 rst_n = 1'b0;                      // well away from any rising edge
        #1;
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL arst_irq got=%b exp=0", irq); end
        total++; if (irq_vector !== 3'd0) begin bad++; $display("FAIL arst_vec got=%0d exp=0", irq_vector); end
        total++; if (bus.dout !== 8'h00) begin bad++; $display("FAIL arst_dout got=%h exp=00", bus.dout); end
        @(negedge clk); rst_n = 1'b1;
        rd(A_PEND, rdv);
        total++; if (rdv !== 8'h00) begin bad++; $display("FAIL arst_pend got=%h exp=00", rdv); end
        rd(A_EN, rdv);
        total++; if (rdv !== 8'h00) begin bad++; $display("FAIL arst_en got=%h exp=00", rdv); end
        rd(A_STAT, rdv);
        total++; if (rdv !== 8'h00) begin bad++; $display("FAIL arst_status got=%h exp=00", rdv); end
    endtask

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0; irq_in = 3'd0; irq_ack = 1'b0; irq_ret = 1'b0;
        bus.din = 8'd0; bus.address = 8'd0; bus.w_en = 1'b0; bus.r_en = 1'b0;
        test_reset();
        test_basic();
        test_priority();
        test_mask();
        test_w1c();
        test_gie();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
